// File: rtl/vga_timing.sv
// vga_timing: pixel-timing generator for the VGA output path.
// Produces hsync/vsync, the active-video enable that drives the colour
// scalers' `en`, the current pixel coordinates and line/frame start pulses.
// Optional feature: define VGA_TEST_PATTERN_EN to build the eight-bar colour
// source on r/g/b; without it r/g/b are tied to zero and no bar logic exists.
module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter values; the counters sit here in reset so the first ce
  // tick wraps them to (0,0) and the first frame is complete.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode boundaries kept one bit wider so a total of exactly 1024 cannot
  // alias an end boundary back to zero.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timings the 10-bit counters cannot represent.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_bad_totals
    $error("vga_timing: H_TOTAL/V_TOTAL out of range");
  end

  // Counter state and registered outputs
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_en_q, video_en_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Position counters: advance one pixel per ce tick, wrap line then frame
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decode sync/enable/pulses from the next position so the registered
  // outputs line up with the registered x/y on the same edge
  always_comb begin
    video_en_d    = ({1'b0, x_d} < H_ACT_END) && ({1'b0, y_d} < V_ACT_END);
    hsync_d       = (({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
    // Pulses only on a tick that actually enters column 0; holding at x=0
    // with ce low must not repeat them.
    line_start_d  = ce && (x_d == 10'd0);
    frame_start_d = ce && (x_d == 10'd0) && (y_d == 10'd0);
  end

  // Timing registers; reset parks at the last pixel of the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_en_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_en_q    <= video_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_en    = video_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  // Eight equal-width vertical bars across the visible width
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  if (H_ACTIVE < 8) begin : g_bad_bar_width
    $error("vga_timing: H_ACTIVE too small for eight colour bars");
  end

  logic [2:0] bar_d;
  logic [1:0] r_q, r_d;
  logic [1:0] g_q, g_d;
  logic [1:0] b_q, b_d;

  // Bar index from the next column; blank outside the visible area
  always_comb begin
    bar_d = 3'(x_d / BAR_W);
    r_d   = video_en_d ? {2{bar_d[2]}} : 2'b00;
    g_d   = video_en_d ? {2{bar_d[1]}} : 2'b00;
    b_d   = video_en_d ? {2{bar_d[0]}} : 2'b00;
  end

  // Colour-bar registers, aligned with x/y
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 2'b00;
      g_q <= 2'b00;
      b_q <= 2'b00;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
`else
  // Pixel data comes from the framebuffer at the top level
  assign r = 2'b00;
  assign g = 2'b00;
  assign b = 2'b00;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing with reduced timing parameters so several whole
// frames fit in a short run. The reference model counts ce ticks since reset
// and derives the position and every output from that count arithmetically.
module tb_vga_timing;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;  // 80
  localparam int VT = VA + VFP + VS + VBP;  // 27
  localparam logic POL = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       hsync, vsync, video_en, line_start, frame_start;
  logic [9:0] x, y;
  logic [1:0] r, g, b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: ce ticks since reset and whether the last edge was a tick
  int   ticks = 0;
  logic ticked = 1'b0;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hsync), .vsync(vsync), .video_en(video_en),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s at t=%0t ticks=%0d: got %0d expected %0d", tag, $time, ticks, got, exp);
    end
  endtask

  task automatic check_all();
    int ex, ey, k, ergb;
    logic ev, ehs, evs;
    if (ticks == 0) begin
      ex = HT - 1;
      ey = VT - 1;
    end else begin
      ex = (ticks - 1) % HT;
      ey = ((ticks - 1) / HT) % VT;
    end
    ev  = (ex < HA) && (ey < VA) && (ticks != 0);
    ehs = (ex >= HA + HFP && ex < HA + HFP + HS) ? POL : ~POL;
    evs = (ey >= VA + VFP && ey < VA + VFP + VS) ? POL : ~POL;
    ergb = 0;
`ifdef VGA_TEST_PATTERN_EN
    if (ev) begin
      k = ex / (HA / 8);
      ergb = (((k >> 2) & 1) * 3 << 4) | (((k >> 1) & 1) * 3 << 2) | ((k & 1) * 3);
    end
`else
    k = 0;
`endif
    check("x", int'(x), ex);
    check("y", int'(y), ey);
    check("video_en", int'(video_en), int'(ev));
    check("hsync", int'(hsync), int'(ehs));
    check("vsync", int'(vsync), int'(evs));
    check("line_start", int'(line_start), int'(ticked && ex == 0));
    check("frame_start", int'(frame_start), int'(ticked && ex == 0 && ey == 0));
    check("rgb", int'({r, g, b}), ergb);
  endtask

  // One clk cycle: apply inputs, advance the model at the edge, check at negedge
  task automatic step(input logic ce_v, input logic rst_v);
    ce = ce_v;
    reset = rst_v;
    @(posedge clk);
    if (rst_v) begin
      ticks = 0;
      ticked = 1'b0;
    end else if (ce_v) begin
      ticks++;
      ticked = 1'b1;
    end else begin
      ticked = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // Reset state
    repeat (3) step(1'b1, 1'b1);
    // Continuous ce: a little over two frames covers line/frame wraps
    repeat (2 * HT * VT + 100) step(1'b1, 1'b0);
    // ce one cycle in four
    for (int i = 0; i < 4 * HT * 3; i++) step((i % 4) == 0, 1'b0);
    // Reset mid-line with ce high, then resume from (0,0)
    while (!(ticks > 0 && ((ticks - 1) % HT) == 30)) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (HT + 5) step(1'b1, 1'b0);
    // Random ce with occasional reset
    for (int i = 0; i < 6000; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 999) == 0));
    end
    // Random-density ce across a full frame
    for (int i = 0; i < HT * VT + 200; i++) step(1'($urandom_range(0, 7) != 0), 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
